// File: rtl/tea_round_engine.sv
// Iterative TEA block cipher: UNROLL chained TEA cycles per clock, one 64-bit block per
// transaction, with valid/ready handshakes on the request and result sides.
module tea_round_engine #(
    parameter int          ROUNDS = 32,
    parameter int          UNROLL = 1,
    parameter logic [31:0] DELTA  = 32'h9e3779b9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_key,
    input  logic [31:0]  in_a,
    input  logic [31:0]  in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_a,
    output logic [31:0]  out_b,
    output logic         out_mode,
    output logic         busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is high only in IDLE and out_valid only in DONE, so at most one side can
    // transfer on any edge, and a request cannot be accepted on the same edge as a drain.

    if (ROUNDS < 1 || (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) ||
        (ROUNDS % UNROLL) != 0) begin : g_param_check
        $error("tea_round_engine: ROUNDS must be >= 1 and a multiple of UNROLL (1, 2, 4 or 8)");
    end

    localparam int          N       = ROUNDS / UNROLL;
    localparam int          CW      = $clog2(N + 1);
    localparam logic [31:0] SUM_DEC = DELTA * 32'(ROUNDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [31:0]   v0;
    logic [31:0]   v1;
    logic [31:0]   sum;
    logic [CW-1:0] cnt;
    logic          run_mode;
    logic [127:0]  key;

    logic [31:0] nxt_v0;
    logic [31:0] nxt_v1;
    logic [31:0] nxt_sum;

    function automatic logic [31:0] tea_f(input logic [31:0] v, input logic [31:0] ka,
                                          input logic [31:0] kb, input logic [31:0] s);
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

    // One clock's worth of rounds; each cycle sees the previous cycle's words and sum.
    always_comb begin
        nxt_v0  = v0;
        nxt_v1  = v1;
        nxt_sum = sum;
        for (int i = 0; i < UNROLL; i++) begin
            if (!run_mode) begin
                nxt_sum = nxt_sum + DELTA;
                nxt_v0  = nxt_v0 + tea_f(nxt_v1, key[127:96], key[95:64], nxt_sum);
                nxt_v1  = nxt_v1 + tea_f(nxt_v0, key[63:32], key[31:0], nxt_sum);
            end else begin
                nxt_v1  = nxt_v1 - tea_f(nxt_v0, key[63:32], key[31:0], nxt_sum);
                nxt_v0  = nxt_v0 - tea_f(nxt_v1, key[127:96], key[95:64], nxt_sum);
                nxt_sum = nxt_sum - DELTA;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            v0       <= '0;
            v1       <= '0;
            sum      <= '0;
            cnt      <= '0;
            run_mode <= 1'b0;
            key      <= '0;
            out_a    <= '0;
            out_b    <= '0;
            out_mode <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        v0       <= in_a;
                        v1       <= in_b;
                        key      <= in_key;
                        run_mode <= in_mode;
                        sum      <= in_mode ? SUM_DEC : 32'd0;
                        cnt      <= CW'(N);
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    v0  <= nxt_v0;
                    v1  <= nxt_v1;
                    sum <= nxt_sum;
                    cnt <= cnt - CW'(1);
                    // Result registers change only here, so they hold through DONE and IDLE.
                    if (cnt == CW'(1)) begin
                        out_a    <= nxt_v0;
                        out_b    <= nxt_v1;
                        out_mode <= run_mode;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_tea_round_engine.sv
// Self-checking bench for tea_round_engine: known-answer table, round trips over three
// parameter sets, back-pressure, mid-run reset and randomized traffic against a block model.
module tb_tea_round_engine;

    localparam logic [31:0]  DELTA  = 32'h9e3779b9;
    localparam logic [127:0] RT_KEY = 128'h95a8882c_9d2cc113_815aa0cd_a1c489f7;
    localparam logic [31:0]  PT_A   = 32'h01234567;
    localparam logic [31:0]  PT_B   = 32'h89abcdef;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic         iv[3];
    logic         im[3];
    logic         orr[3];
    logic [127:0] ik[3];
    logic [31:0]  ia[3];
    logic [31:0]  ib[3];
    logic         irdy[3];
    logic         ov[3];
    logic         om[3];
    logic         bz[3];
    logic [31:0]  oa[3];
    logic [31:0]  ob[3];

    int tests = 0;
    int fails = 0;
    int rounds_of[3] = '{32, 16, 64};
    int n_of[3]      = '{32, 4, 64};
    logic [64:0] exp_q[$];

    typedef struct {
        int           inst;
        logic         mode;
        logic [127:0] key;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  exp_a;
        logic [31:0]  exp_b;
    } vec_t;
    vec_t vecs[6];

    // ---------------- clock / DUTs ----------------
    always #5 clk = ~clk;

    tea_round_engine u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .in_mode(im[0]),
        .in_key(ik[0]), .in_a(ia[0]), .in_b(ib[0]), .out_valid(ov[0]), .out_ready(orr[0]),
        .out_a(oa[0]), .out_b(ob[0]), .out_mode(om[0]), .busy(bz[0])
    );

    tea_round_engine #(.ROUNDS(16), .UNROLL(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .in_mode(im[1]),
        .in_key(ik[1]), .in_a(ia[1]), .in_b(ib[1]), .out_valid(ov[1]), .out_ready(orr[1]),
        .out_a(oa[1]), .out_b(ob[1]), .out_mode(om[1]), .busy(bz[1])
    );

    tea_round_engine #(.ROUNDS(64), .UNROLL(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .in_mode(im[2]),
        .in_key(ik[2]), .in_a(ia[2]), .in_b(ib[2]), .out_valid(ov[2]), .out_ready(orr[2]),
        .out_a(oa[2]), .out_b(ob[2]), .out_mode(om[2]), .busy(bz[2])
    );

    // ---------------- reference model: whole block at once ----------------
    function automatic logic [63:0] tea_model(input logic m, input logic [127:0] k,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input int rounds);
        logic [31:0] x, y, s, k0, k1, k2, k3;
        x  = a;
        y  = b;
        k0 = k[127:96];
        k1 = k[95:64];
        k2 = k[63:32];
        k3 = k[31:0];
        if (!m) begin
            s = 32'd0;
            for (int r = 0; r < rounds; r++) begin
                s = s + DELTA;
                x = x + (((y << 4) + k0) ^ (y + s) ^ ((y >> 5) + k1));
                y = y + (((x << 4) + k2) ^ (x + s) ^ ((x >> 5) + k3));
            end
        end else begin
            s = DELTA * 32'(rounds);
            for (int r = 0; r < rounds; r++) begin
                y = y - (((x << 4) + k2) ^ (x + s) ^ ((x >> 5) + k3));
                x = x - (((y << 4) + k0) ^ (y + s) ^ ((y >> 5) + k1));
                s = s - DELTA;
            end
        end
        return {x, y};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input int i, input logic m, input logic [127:0] k,
                        input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        im[i] = m;
        ik[i] = k;
        ia[i] = a;
        ib[i] = b;
        iv[i] = 1'b1;
        n = 0;
        while (!irdy[i] && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_seen", 128'(irdy[i]), 128'(1));
        @(posedge clk);
        #1 iv[i] = 1'b0;
        check("busy_after_accept", 128'({bz[i], irdy[i]}), 128'(2'b10));
    endtask

    task automatic wait_valid(input int i, output int lat);
        lat = 0;
        while (lat < 500) begin
            @(posedge clk);
            lat++;
            #1;
            if (ov[i]) break;
        end
        check("out_valid_seen", 128'(ov[i]), 128'(1));
    endtask

    task automatic drain(input int i);
        orr[i] = 1'b1;
        @(posedge clk);
        #1 orr[i] = 1'b0;
        check("idle_after_drain", 128'({ov[i], irdy[i]}), 128'(2'b01));
    endtask

    task automatic recv(input int i, output logic [31:0] ra, output logic [31:0] rb,
                        output logic rm, output int lat);
        wait_valid(i, lat);
        ra = oa[i];
        rb = ob[i];
        rm = om[i];
        drain(i);
    endtask

    task automatic round_trip(input int i);
        logic [31:0] ca, cb, pa, pb;
        logic        rm;
        logic [63:0] ref_ct;
        int          lat;
        ref_ct = tea_model(1'b0, RT_KEY, PT_A, PT_B, rounds_of[i]);
        send(i, 1'b0, RT_KEY, PT_A, PT_B);
        recv(i, ca, cb, rm, lat);
        check($sformatf("rt%0d_enc", i), 128'({rm, ca, cb}), 128'({1'b0, ref_ct}));
        send(i, 1'b1, RT_KEY, ca, cb);
        if (i == 1) check("dec_sum_init_r16", 128'(u_dut1.sum), 128'(32'he3779b90));
        recv(i, pa, pb, rm, lat);
        check($sformatf("rt%0d_dec", i), 128'({rm, pa, pb}), 128'({1'b1, PT_A, PT_B}));
        check($sformatf("rt%0d_lat", i), 128'(lat), 128'(n_of[i]));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] ra, rb;
        logic        rm;
        int          lat;
        logic [63:0] m;
        logic [127:0] rkey;
        int          sent, got, cyc;
        logic        pending;
        logic [64:0] e;

        for (int i = 0; i < 3; i++) begin
            iv[i]  = 1'b0;
            im[i]  = 1'b0;
            orr[i] = 1'b0;
            ik[i]  = '0;
            ia[i]  = '0;
            ib[i]  = '0;
        end

        // Reset with a request held on inst 0: nothing may be accepted.
        iv[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_values", 128'({irdy[0], ov[0], bz[0], om[0], oa[0], ob[0]}),
              128'({1'b1, 1'b0, 1'b0, 1'b0, 64'd0}));
        check("reset_internal", 128'({u_dut0.v0, u_dut0.v1, u_dut0.sum}), 128'(0));
        @(negedge clk);
        iv[0] = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("idle_after_reset", 128'({irdy[0], bz[0]}), 128'(2'b10));

        // Table of vectors: known answers plus model-derived entries.
        rkey = {$urandom, $urandom, $urandom, $urandom};
        vecs[0] = '{0, 1'b0, 128'd0, 32'd0, 32'd0, 32'h41ea3a0a, 32'h94baa940};
        vecs[1] = '{0, 1'b1, 128'd0, 32'h41ea3a0a, 32'h94baa940, 32'd0, 32'd0};
        for (int i = 0; i < 3; i++) begin
            m = tea_model(1'b0, RT_KEY, PT_A, PT_B, rounds_of[i]);
            vecs[2 + i] = '{i, 1'b0, RT_KEY, PT_A, PT_B, m[63:32], m[31:0]};
        end
        ra = $urandom;
        rb = $urandom;
        m = tea_model(1'b1, rkey, ra, rb, 16);
        vecs[5] = '{1, 1'b1, rkey, ra, rb, m[63:32], m[31:0]};

        for (int v = 0; v < 6; v++) begin
            send(vecs[v].inst, vecs[v].mode, vecs[v].key, vecs[v].a, vecs[v].b);
            recv(vecs[v].inst, ra, rb, rm, lat);
            check($sformatf("vec%0d_out", v), 128'({rm, ra, rb}),
                  128'({vecs[v].mode, vecs[v].exp_a, vecs[v].exp_b}));
            check($sformatf("vec%0d_lat", v), 128'(lat), 128'(n_of[vecs[v].inst]));
        end

        for (int i = 0; i < 3; i++) round_trip(i);

        // Back-pressure with inputs toggling during RUN and DONE.
        m = tea_model(1'b0, RT_KEY, PT_A, PT_B, 32);
        send(0, 1'b0, RT_KEY, PT_A, PT_B);
        cyc = 0;
        while (!ov[0] && cyc < 500) begin
            @(negedge clk);
            iv[0] = 1'($urandom_range(0, 1));
            ia[0] = $urandom;
            ik[0] = {$urandom, $urandom, $urandom, $urandom};
            im[0] = 1'($urandom_range(0, 1));
            cyc++;
        end
        check("bp_valid_seen", 128'(ov[0]), 128'(1));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", c),
                  128'({ov[0], irdy[0], bz[0], om[0], oa[0], ob[0]}),
                  128'({1'b1, 1'b0, 1'b0, 1'b0, m}));
            iv[0] = 1'($urandom_range(0, 1));
            ia[0] = $urandom;
            ik[0] = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        iv[0]  = 1'b0;
        orr[0] = 1'b1;
        @(posedge clk);
        #1 orr[0] = 1'b0;
        check("bp_release", 128'({ov[0], irdy[0], oa[0], ob[0]}), 128'({2'b01, m}));

        // Asynchronous reset in the middle of RUN.
        send(0, 1'b0, 128'd0, 32'd0, 32'd0);
        repeat (9) @(posedge clk);
        #2 check("busy_mid_run", 128'(bz[0]), 128'(1));
        rst_n = 1'b0;
        #1 check("async_reset", 128'({bz[0], ov[0], irdy[0], om[0], oa[0], ob[0]}),
                 128'({1'b0, 1'b0, 1'b1, 1'b0, 64'd0}));
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 1'b0, 128'd0, 32'd0, 32'd0);
        recv(0, ra, rb, rm, lat);
        check("kat_after_reset", 128'({ra, rb}), 128'({32'h41ea3a0a, 32'h94baa940}));
        check("kat_after_reset_lat", 128'(lat), 128'(32));

        // Randomized back-to-back traffic with gaps on both sides.
        sent = 0;
        got = 0;
        cyc = 0;
        pending = 1'b0;
        while (got < 100 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!pending && sent < 100 && $urandom_range(0, 3) != 0) begin
                pending = 1'b1;
                im[0] = 1'($urandom_range(0, 1));
                ik[0] = {$urandom, $urandom, $urandom, $urandom};
                ia[0] = $urandom;
                ib[0] = $urandom;
            end
            iv[0]  = pending;
            orr[0] = ($urandom_range(0, 2) != 0);
            if (pending && irdy[0]) begin
                exp_q.push_back({im[0], tea_model(im[0], ik[0], ia[0], ib[0], 32)});
                pending = 1'b0;
                sent++;
            end
            if (ov[0] && orr[0]) begin
                if (exp_q.size() == 0) begin
                    check("rand_spurious", 128'(ov[0]), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rand_blk%0d", got), 128'({om[0], oa[0], ob[0]}), 128'(e));
                end
                got++;
            end
        end
        @(negedge clk);
        iv[0]  = 1'b0;
        orr[0] = 1'b0;
        check("rand_count", 128'(got), 128'(100));
        check("rand_sent", 128'(sent), 128'(100));
        check("rand_q_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
